alu_pipe: RTL and testbench

Parametrised, handshaked successor to the single-cycle ALU. It executes add, subtract, even-parity, branch-compare and serial shift operations on WIDTH-bit operands, and registers every result behind a valid/ready output port. Shifts are multi-cycle, one bit per clock. The block sits between the decode stage, which supplies `res` ($c1) and `register` ($c2), and the writeback/branch logic, which consumes `out` and `compres`.

---
 rtl/alu_pipe.sv | 156 +++++++++++++++
 tb/tb_alu_pipe.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with add, sub, even parity, branch compare
// and one-bit-per-clock serial shifts; results held until taken.
//
// Ports:
//   clock, reset       rising-edge clock, async active-high reset
//   in_valid/in_ready  request handshake (in_ready has no in_valid path)
//   op, res, register  opcode, operand A, operand B
//   eq, ltgt           branch compare mode / kind
//   out_valid/out_ready result handshake
//   out                registered result
//   compres            branch compare result
//   carry              add carry-out / sub borrow
//   err                accepted opcode was illegal
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] res,
    input  logic [WIDTH-1:0] register,
    input  logic             eq,
    input  logic [1:0]       ltgt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             compres,
    output logic             carry,
    output logic             err
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_BR   = 4'b0100;
    localparam logic [3:0] OP_EPAR = 4'b0101;
    localparam logic [3:0] OP_SHL  = 4'b0110;
    localparam logic [3:0] OP_SHR  = 4'b0111;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    state_t state;
    state_t state_nx;

    logic             acc;
    logic [SHW-1:0]   amt;
    logic [SHW-1:0]   cnt;
    logic             is_shift;
    logic             go_shift;
    logic             shl;
    logic             lt;
    logic             eqv;
    logic             cmp;
    logic [WIDTH-1:0] r_out;
    logic             r_cmp;
    logic             r_cy;
    logic             r_err;

    // Ready is a pure function of state, out_ready and reset.
    assign in_ready  = !reset &&
                       (state == IDLE || (state == HOLD && out_ready));
    assign acc       = in_valid && in_ready;
    assign out_valid = (state == HOLD);

    assign amt      = register[SHW-1:0];
    assign is_shift = (op == OP_SHL) || (op == OP_SHR);
    assign go_shift = is_shift && (amt != '0);

    // Branch compares are register-vs-res, unsigned.
    assign lt  = register < res;
    assign eqv = register == res;

    always_comb begin
        cmp = 1'b0;
        case (ltgt)
            2'd0:    cmp = eq ? eqv : !eqv;
            2'd1:    cmp = eq ? (lt || eqv) : lt;
            2'd2:    cmp = eq ? !lt : !(lt || eqv);
            default: cmp = 1'b0;
        endcase
    end

    always_comb begin
        r_out = '0;
        r_cmp = 1'b0;
        r_cy  = 1'b0;
        r_err = 1'b0;
        case (op)
            OP_ADD:  {r_cy, r_out} = {1'b0, res} + {1'b0, register};
            OP_SUB: begin
                r_out = res - register;
                r_cy  = res < register;
            end
            OP_EPAR: r_out = {{(WIDTH-1){1'b0}}, ^res};
            OP_BR: begin
                r_out = res;
                r_cmp = cmp;
            end
            // Shift loads the operand; a zero amount is already final.
            OP_SHL, OP_SHR: r_out = res;
            default: r_err = 1'b1;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, HOLD: begin
                if (acc)
                    state_nx = go_shift ? SHIFT : HOLD;
                else if (state == HOLD && out_ready)
                    state_nx = IDLE;
            end
            SHIFT: begin
                if (cnt == SHW'(1))
                    state_nx = HOLD;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out     <= '0;
            compres <= 1'b0;
            carry   <= 1'b0;
            err     <= 1'b0;
            cnt     <= '0;
            shl     <= 1'b0;
        end else if (acc) begin
            out     <= r_out;
            compres <= r_cmp;
            carry   <= r_cy;
            err     <= r_err;
            cnt     <= go_shift ? amt : '0;
            shl     <= !op[0];
        end else if (state == SHIFT) begin
            out <= shl ? (out << 1) : (out >> 1);
            cnt <= cnt - SHW'(1);
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed stimulus for alu_pipe with a scoreboard model
// checked every cycle, plus literal expectations per vector.
module tb_alu_pipe;

    localparam int W = 16;

    logic         clock     = 1'b0;
    logic         reset     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    logic [3:0]   op        = '0;
    logic [W-1:0] res       = '0;
    logic [W-1:0] register  = '0;
    logic         eq        = 1'b0;
    logic [1:0]   ltgt      = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out;
    logic         compres;
    logic         carry;
    logic         err;

    alu_pipe #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .res       (res),
        .register  (register),
        .eq        (eq),
        .ltgt      (ltgt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .compres   (compres),
        .carry     (carry),
        .err       (err)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] o;
        logic         cp;
        logic         cy;
        logic         er;
    } exp_t;

    function automatic exp_t model(input logic [3:0] o,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic e,
                                   input logic [1:0] l);
        exp_t         r;
        logic [W:0]   s;
        int unsigned  n;
        r.o  = '0;
        r.cp = 1'b0;
        r.cy = 1'b0;
        r.er = 1'b0;
        n    = int'(b % W);
        case (o)
            4'b0000: begin
                s    = {1'b0, a} + {1'b0, b};
                r.o  = s[W-1:0];
                r.cy = s[W];
            end
            4'b0001: begin
                r.o  = a - b;
                r.cy = (a < b);
            end
            4'b0101: r.o = W'(^a);
            4'b0100: begin
                r.o = a;
                case ({e, l})
                    3'b100:  r.cp = (b == a);
                    3'b101:  r.cp = (b <= a);
                    3'b110:  r.cp = (b >= a);
                    3'b000:  r.cp = (b != a);
                    3'b001:  r.cp = (b < a);
                    3'b010:  r.cp = (b > a);
                    default: r.cp = 1'b0;
                endcase
            end
            4'b0110: r.o = a << n;
            4'b0111: r.o = a >> n;
            default: r.er = 1'b1;
        endcase
        return r;
    endfunction

    exp_t          q[$];
    logic          prev_hold = 1'b0;
    logic [19:0]   prev_snap = '0;

    // Scoreboard: push on acceptance, pop on output handshake,
    // and hold stability whenever the consumer stalls.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            q.delete();
            prev_hold = 1'b0;
            check("rst_out", {16'h0, out}, 32'h0);
            check("rst_flags",
                  {27'h0, out_valid, compres, carry, err, in_ready},
                  32'h0);
        end else begin
            if (prev_hold)
                check("hold_stable",
                      {12'h0, out_valid, out, compres, carry, err},
                      {12'h0, 1'b1, prev_snap[18:0]});
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("sb_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("sb_result",
                          {13'h0, out, compres, carry, err},
                          {13'h0, e.o, e.cp, e.cy, e.er});
                end
            end
            if (in_valid && in_ready)
                q.push_back(model(op, res, register, eq, ltgt));
            prev_hold = out_valid && !out_ready;
            prev_snap = {1'b0, out, compres, carry, err};
        end
    end

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic e,
                          input logic [1:0] l, input logic [W-1:0] xo,
                          input logic xcp, input logic xcy,
                          input logic xer, input int xlat,
                          input string nm);
        int wt;
        int lat;
        int low;
        @(posedge clock);
        #1;
        op       = o;
        res      = a;
        register = b;
        eq       = e;
        ltgt     = l;
        in_valid = 1'b1;
        wt = 0;
        @(negedge clock);
        while (!in_ready && wt < 40) begin
            @(negedge clock);
            wt++;
        end
        if (wt >= 40) check({nm, "_accept_timeout"}, 32'd1, 32'd0);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        res      = ~a;
        register = ~b;
        op       = 4'b1111;
        lat = 1;
        low = 0;
        @(negedge clock);
        while (!out_valid && lat < 40) begin
            if (!in_ready) low++;
            @(negedge clock);
            lat++;
        end
        check({nm, "_latency"}, lat, xlat);
        check({nm, "_busy"}, low, xlat - 1);
        check({nm, "_out"}, {16'h0, out}, {16'h0, xo});
        check({nm, "_flags"}, {29'h0, compres, carry, err},
              {29'h0, xcp, xcy, xer});
    endtask

    logic [2:0] br_tab [2][4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rv;
        logic [2:0]   row;

        br_tab[0] = '{3'b011, 3'b010, 3'b001, 3'b000};
        br_tab[1] = '{3'b100, 3'b110, 3'b101, 3'b000};

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_ready", {31'h0, in_ready}, 32'd1);
        check("post_rst_valid", {31'h0, out_valid}, 32'd0);

        run_op(4'b0000, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 0, 1, 0, 1,
               "add_wrap");
        run_op(4'b0001, 16'd3, 16'd5, 0, 0, 16'hFFFE, 0, 1, 0, 1,
               "sub_borrow");
        run_op(4'b0001, 16'd9, 16'd4, 0, 0, 16'h0005, 0, 0, 0, 1,
               "sub_plain");
        run_op(4'b0101, 16'h8001, 16'h0, 0, 0, 16'h0000, 0, 0, 0, 1,
               "epar_even");
        run_op(4'b0101, 16'h8000, 16'h0, 0, 0, 16'h0001, 0, 0, 0, 1,
               "epar_odd");
        run_op(4'b1111, 16'h1234, 16'h5678, 1, 1, 16'h0000, 0, 0, 1, 1,
               "illegal");

        for (int e = 0; e < 2; e++)
            for (int l = 0; l < 4; l++)
                for (int p = 0; p < 3; p++) begin
                    rv  = (p == 0) ? 16'd5 : (p == 1) ? 16'd4 : 16'd6;
                    row = br_tab[e][l];
                    run_op(4'b0100, 16'd5, rv, e[0], l[1:0], 16'd5,
                           row[2-p], 0, 0, 1, "branch");
                end

        run_op(4'b0110, 16'h0001, 16'd15, 0, 0, 16'h8000, 0, 0, 0, 16,
               "shl15");
        run_op(4'b0111, 16'hA5A5, 16'd0, 0, 0, 16'hA5A5, 0, 0, 0, 1,
               "shr0");
        run_op(4'b0111, 16'h8000, 16'd3, 0, 0, 16'h1000, 0, 0, 0, 4,
               "shr3");

        // Back-to-back throughput with the consumer always ready.
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            if (i < 3) begin
                op       = 4'b0000;
                res      = 16'(i * 7);
                register = 16'd1;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clock);
            if (i > 0) check("b2b_valid", {31'h0, out_valid}, 32'd1);
        end

        // Backpressure, then same-edge retire and accept.
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        op        = 4'b0000;
        res       = 16'd1;
        register  = 16'd2;
        in_valid  = 1'b1;
        @(posedge clock);
        #1;
        res      = 16'd10;
        register = 16'd20;
        repeat (4) begin
            @(negedge clock);
            check("bp_valid", {31'h0, out_valid}, 32'd1);
            check("bp_ready", {31'h0, in_ready}, 32'd0);
            check("bp_out", {16'h0, out}, 32'd3);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        @(negedge clock);
        check("bp_pass_ready", {31'h0, in_ready}, 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(negedge clock);
        check("bp_next_valid", {31'h0, out_valid}, 32'd1);
        check("bp_next_out", {16'h0, out}, 32'd30);

        // Reset in the middle of a shift by 10.
        @(posedge clock);
        #1;
        op       = 4'b0110;
        res      = 16'h0001;
        register = 16'd10;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_out", {16'h0, out}, 32'd0);
        check("mid_rst_valid", {31'h0, out_valid}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rel_ready", {31'h0, in_ready}, 32'd1);
        check("rel_valid", {31'h0, out_valid}, 32'd0);
        run_op(4'b0000, 16'd2, 16'd3, 0, 0, 16'd5, 0, 0, 0, 1,
               "add_after_rst");

        @(posedge clock);
        @(negedge clock);
        check("sb_drained", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
